alu_arbiter: RTL

- Shares one combinational `alu` instance between NUM_REQ independent requesters, such as an integer pipe, an address-generation unit and a debug port.
- Each requester uses a valid/ready request channel. A round-robin grant picks one request per cycle and drives the ALU operands.
- The result is registered into a single output slot, tagged with the winning requester's ID, and returned over one valid/ready response channel.

---
 rtl/alu_arbiter_pkg.sv | 26 ++
 rtl/alu.sv | 29 ++
 rtl/alu_arbiter_rr_arbiter.sv | 55 +++++
 rtl/alu_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: func3 encodings, response-slot state and
// the per-requester ALU request bundle.
package alu_arbiter_pkg;

    localparam logic [2:0] ADD_SUB = 3'b000;
    localparam logic [2:0] SLL     = 3'b001;
    localparam logic [2:0] SLT     = 3'b010;
    localparam logic [2:0] SLTU    = 3'b011;
    localparam logic [2:0] XOR     = 3'b100;
    localparam logic [2:0] SRL_SRA = 3'b101;
    localparam logic [2:0] OR      = 3'b110;
    localparam logic [2:0] AND     = 3'b111;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] operand1;
        logic [31:0] operand2;
        logic [2:0]  func3;
        logic        subsra;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU; subsra selects SUB for ADD_SUB and SRA for
// SRL_SRA. Shift amounts use the full operand2 value.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [31:0] operand1_i,
    input  logic [31:0] operand2_i,
    input  logic [2:0]  func3_i,
    input  logic        subsra_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = '0;
        case (func3_i)
            ADD_SUB: result_o = subsra_i ? (operand1_i - operand2_i) : (operand1_i + operand2_i);
            SLL:     result_o = operand1_i << operand2_i;
            SLT:     result_o = {31'b0, ($signed(operand1_i) < $signed(operand2_i))};
            SLTU:    result_o = {31'b0, (operand1_i < operand2_i)};
            XOR:     result_o = operand1_i ^ operand2_i;
            SRL_SRA: result_o = subsra_i ? 32'($signed(operand1_i) >>> operand2_i)
                                         : (operand1_i >> operand2_i);
            OR:      result_o = operand1_i | operand2_i;
            AND:     result_o = operand1_i & operand2_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// searching upward with wrap; the pointer moves past the winner on advance.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            found;
    int unsigned     idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_i[idx]) begin
                found     = 1'b1;
                gnt_idx_o = ID_W'(idx);
            end
        end
        if (en_i && found) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (gnt_idx_o == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters through a round-robin grant and a
// single registered response slot. Define ALU_ARBITER_STATS_EN for counters.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_operand1,
    input  logic [NUM_REQ*32-1:0] req_operand2,
    input  logic [NUM_REQ*3-1:0]  req_func3,
    input  logic [NUM_REQ-1:0]    req_subsra,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_result,
    output logic [ID_W-1:0]       rsp_id
`ifdef ALU_ARBITER_STATS_EN
   ,input  logic                  stat_clear,
    output logic [31:0]           stat_ops,
    output logic [31:0]           stat_stall
`endif
);

    state_e          state_q, state_d;
    logic [31:0]     result_q, result_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            can_accept;
    logic            transfer;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0] gnt_idx;
    alu_req_t        reqs [NUM_REQ];
    alu_req_t        sel_req;
    logic [31:0]     alu_result;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            reqs[i].operand1 = req_operand1[32*i +: 32];
            reqs[i].operand2 = req_operand2[32*i +: 32];
            reqs[i].func3    = req_func3[3*i +: 3];
            reqs[i].subsra   = req_subsra[i];
        end
    end

    assign can_accept = (state_q == EMPTY) || rsp_ready;

    // Reset gates the enable so req_ready stays low while rst is held.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req_valid),
        .en_i      (can_accept && !rst),
        .advance_i (transfer),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign req_ready = gnt;
    assign transfer  = |(req_valid & gnt);
    assign sel_req   = reqs[gnt_idx];

    alu u_alu (
        .operand1_i (sel_req.operand1),
        .operand2_i (sel_req.operand2),
        .func3_i    (sel_req.func3),
        .subsra_i   (sel_req.subsra),
        .result_o   (alu_result)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        id_d     = id_q;
        if (transfer) begin
            state_d  = FULL;
            result_d = alu_result;
            id_d     = gnt_idx;
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            result_q <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            id_q     <= id_d;
        end
    end

    assign rsp_valid  = (state_q == FULL);
    assign rsp_result = result_q;
    assign rsp_id     = id_q;

`ifdef ALU_ARBITER_STATS_EN
    logic [31:0] stat_ops_q, stat_ops_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_ops_d   = stat_ops_q;
        stat_stall_d = stat_stall_q;
        if (stat_clear) begin
            stat_ops_d   = '0;
            stat_stall_d = '0;
        end else begin
            if (transfer) begin
                stat_ops_d = stat_ops_q + 32'd1;
            end
            if (|req_valid && !can_accept) begin
                stat_stall_d = stat_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_ops_q   <= stat_ops_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_ops   = stat_ops_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule
